// File: rtl/arb_pkg.sv
// Shared arbitration mode encodings and sizing helper
// for the registered request arbiter.
package arb_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Combinational first-set search over a request vector,
// starting at a given index and wrapping modulo N.
module rr_prio_pick
  import arb_pkg::*;
#(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o,
  output logic [N-1:0]     onehot_o
);

  int k;

  always_comb begin
    found_o  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    k        = 0;
    for (int i = 0; i < N; i++) begin
      // start is always < N, so one subtraction folds the wrap
      k = int'(start_i) + i;
      if (k >= N) k = k - N;
      if (!found_o && req_i[k]) begin
        found_o     = 1'b1;
        idx_o       = IDX_W'(k);
        onehot_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter_reg.sv
// Registered N-channel request arbiter and payload selector,
// fixed-priority or round-robin chosen at run time.
module req_arbiter_reg
  import arb_pkg::*;
#(
  parameter  int N_CH   = 4,
  parameter  int DATA_W = 2,
  localparam int IDX_W  = clog2_min1(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH-1:0]          req_i,
  input  logic [N_CH*DATA_W-1:0]   data_i,
  input  logic                     mode_i,
  input  logic                     hold_i,
  output logic                     out_valid_o,
  output logic [DATA_W-1:0]        out_data_o,
  output logic [N_CH-1:0]          grant_o,
  output logic [IDX_W-1:0]         grant_idx_o
);

  logic             fx_found, rr_found;
  logic [IDX_W-1:0] fx_idx, rr_idx;
  logic [N_CH-1:0]  fx_oh, rr_oh;

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [N_CH-1:0]  win_oh;
  logic [DATA_W-1:0] win_data;

  logic              valid_d, valid_q;
  logic [DATA_W-1:0] data_d, data_q;
  logic [N_CH-1:0]   grant_d, grant_q;
  logic [IDX_W-1:0]  idx_d, idx_q;
  logic [IDX_W-1:0]  rr_ptr_d, rr_ptr_q;
  logic              upd_en;

  rr_prio_pick #(.N(N_CH), .IDX_W(IDX_W)) u_fx (
    .req_i   (req_i),
    .start_i ({IDX_W{1'b0}}),
    .found_o (fx_found),
    .idx_o   (fx_idx),
    .onehot_o(fx_oh)
  );

  rr_prio_pick #(.N(N_CH), .IDX_W(IDX_W)) u_rr (
    .req_i   (req_i),
    .start_i (rr_ptr_q),
    .found_o (rr_found),
    .idx_o   (rr_idx),
    .onehot_o(rr_oh)
  );

  always_comb begin
    win_found = fx_found;
    win_idx   = fx_idx;
    win_oh    = fx_oh;
    if (mode_i == MODE_RR) begin
      win_found = rr_found;
      win_idx   = rr_idx;
      win_oh    = rr_oh;
    end
    win_data = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (IDX_W'(k) == win_idx)
        win_data = data_i[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    upd_en   = !hold_i && win_found;
    valid_d  = hold_i ? valid_q : win_found;
    grant_d  = hold_i ? grant_q : (win_found ? win_oh : '0);
    data_d   = win_data;
    idx_d    = win_idx;
    rr_ptr_d = (win_idx == IDX_W'(N_CH - 1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      grant_q  <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      rr_ptr_q <= '0;
    end else begin
      valid_q <= valid_d;
      grant_q <= grant_d;
      // payload, index and pointer move only on a real grant
      if (upd_en) begin
        data_q   <= data_d;
        idx_q    <= idx_d;
        rr_ptr_q <= rr_ptr_d;
      end
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign grant_o     = grant_q;
  assign grant_idx_o = idx_q;

endmodule

// File: tb/tb_req_arbiter_reg.sv
// Directed scoreboard bench for req_arbiter_reg, 4-channel
// main instance plus a 3-channel wrap instance.
module tb_req_arbiter_reg;

  typedef struct {
    logic       v;
    logic [1:0] d;
    logic [3:0] g;
    logic [1:0] i;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [7:0] data;
  logic       mode;
  logic       hold;
  logic       o_v;
  logic [1:0] o_d;
  logic [3:0] o_g;
  logic [1:0] o_i;

  logic       rst3;
  logic [2:0] req3;
  logic [5:0] data3;
  logic       mode3;
  logic       hold3;
  logic       o3_v;
  logic [1:0] o3_d;
  logic [2:0] o3_g;
  logic [1:0] o3_i;

  int errors;
  int checks;

  exp_t q[$];
  exp_t q3[$];

  logic       m_v;
  logic [1:0] m_d;
  logic [3:0] m_g;
  logic [1:0] m_i;
  int         m_ptr;

  req_arbiter_reg #(.N_CH(4), .DATA_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .data_i     (data),
    .mode_i     (mode),
    .hold_i     (hold),
    .out_valid_o(o_v),
    .out_data_o (o_d),
    .grant_o    (o_g),
    .grant_idx_o(o_i)
  );

  req_arbiter_reg #(.N_CH(3), .DATA_W(2)) dut3 (
    .clk        (clk),
    .rst        (rst3),
    .req_i      (req3),
    .data_i     (data3),
    .mode_i     (mode3),
    .hold_i     (hold3),
    .out_valid_o(o3_v),
    .out_data_o (o3_d),
    .grant_o    (o3_g),
    .grant_idx_o(o3_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference model of one clock edge for the 4-channel instance
  task automatic model_edge();
    int w;
    w = -1;
    if (rst) begin
      m_v = 0; m_d = 0; m_g = 0; m_i = 0; m_ptr = 0;
    end else if (!hold) begin
      if (mode) begin
        for (int n = 0; n < 4; n++)
          if (w < 0 && req[(m_ptr + n) % 4]) w = (m_ptr + n) % 4;
      end else begin
        for (int n = 3; n >= 0; n--)
          if (req[n]) w = n;
      end
      if (w >= 0) begin
        m_v   = 1;
        m_g   = 4'(1 << w);
        m_i   = 2'(w);
        m_d   = data[w*2 +: 2];
        m_ptr = (w + 1) % 4;
      end else begin
        m_v = 0;
        m_g = 0;
      end
    end
  endtask

  task automatic cyc(input string tag, input logic r,
                     input logic [3:0] rq, input logic md,
                     input logic hd);
    exp_t e;
    @(negedge clk);
    rst  = r;
    req  = rq;
    mode = md;
    hold = hd;
    model_edge();
    e.v = m_v; e.d = m_d; e.g = m_g; e.i = m_i;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      errors++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = q.pop_front();
      chk({tag, "_valid"}, 32'(o_v), 32'(e.v));
      chk({tag, "_data"},  32'(o_d), 32'(e.d));
      chk({tag, "_grant"}, 32'(o_g), 32'(e.g));
      chk({tag, "_idx"},   32'(o_i), 32'(e.i));
    end
  endtask

  initial begin
    exp_t e;
    errors = 0;
    checks = 0;
    m_v = 0; m_d = 0; m_g = 0; m_i = 0; m_ptr = 0;
    rst = 1; req = 0; mode = 0; hold = 0;
    data = {2'b11, 2'b10, 2'b01, 2'b00};
    rst3 = 1; req3 = 0; mode3 = 1; hold3 = 0;
    data3 = {2'b10, 2'b01, 2'b11};

    cyc("rst0", 1, 4'b1111, 1, 0);
    cyc("rst1", 1, 4'b1111, 1, 0);

    for (int n = 0; n < 5; n++)
      cyc($sformatf("rr%0d", n), 0, 4'b1111, 1, 0);

    cyc("fixed", 0, 4'b1010, 0, 0);
    cyc("rr_switch", 0, 4'b1011, 1, 0);
    cyc("rr_single", 0, 4'b0010, 1, 0);

    cyc("grant_10", 0, 4'b0100, 0, 0);
    cyc("idle0", 0, 4'b0000, 0, 0);
    cyc("idle1", 0, 4'b0000, 1, 0);

    cyc("pre_hold", 0, 4'b1000, 0, 0);
    for (int n = 0; n < 3; n++)
      cyc($sformatf("hold%0d", n), 0, 4'b0100, 1, 1);
    cyc("rst_hold", 1, 4'b0100, 1, 1);
    cyc("post_rst_rr", 0, 4'b1111, 1, 0);

    // three-channel wrap: 0,2,0,2 with start pointer reset to 0
    @(negedge clk);
    rst3 = 0;
    req3 = 3'b101;
    for (int n = 0; n < 4; n++) begin
      e.v = 1;
      e.i = (n % 2 == 0) ? 2'd0 : 2'd2;
      e.g = (n % 2 == 0) ? 4'b0001 : 4'b0100;
      e.d = (n % 2 == 0) ? 2'b11 : 2'b10;
      q3.push_back(e);
    end
    for (int n = 0; n < 4; n++) begin
      @(posedge clk);
      #1;
      e = q3.pop_front();
      chk($sformatf("n3_%0d_valid", n), 32'(o3_v), 32'(e.v));
      chk($sformatf("n3_%0d_idx", n), 32'(o3_i), 32'(e.i));
      chk($sformatf("n3_%0d_grant", n), 32'(o3_g), 32'(e.g[2:0]));
      chk($sformatf("n3_%0d_data", n), 32'(o3_d), 32'(e.d));
      chk($sformatf("n3_%0d_no3", n), 32'(o3_i != 2'd3), 32'(1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
